// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// The entry field widths set the default port widths of instr_fetch_buffer.
package instr_fetch_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear.
// The head is always the oldest stored entry and is read straight from storage.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o
);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  always_comb begin
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  count_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CntW'(Depth));
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !clear_i && count_q == CntW'(Depth)));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Sequential instruction fetch unit: issues 1-cycle-latency RAM reads under a
// credit limit and queues returned words for the core; redirects flush everything.
module instr_fetch_buffer
  import instr_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = ADDR_W,
  parameter int unsigned          DATA_WIDTH = DATA_W,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 16'h8000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic                    branch_i,
  input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
  output logic                    fetch_valid_o,
  input  logic                    fetch_ready_i,
  output logic [DATA_WIDTH-1:0]   fetch_rdata_o,
  output logic [ADDR_WIDTH-1:0]   fetch_addr_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned    CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0]  DepthOcc = (CntW + 1)'(FIFO_DEPTH);

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    inflight_q, drop_q;

  logic                    issue, push, pop;
  logic [CntW-1:0]         count;
  logic [CntW:0]           occupancy;
  fetch_entry_t            push_entry, head;
  logic                    unused_branch_lsb;

  assign unused_branch_lsb = ^branch_addr_i[1:0];

  // Credit check covers both buffered words and the one response still on the bus.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
  assign issue     = (state_q == RUN) && (occupancy < DepthOcc);

  // A redirect kills the response landing this cycle; drop_q kills the next one.
  assign push = inflight_q && !drop_q && !branch_i;
  assign pop  = fetch_valid_o && fetch_ready_i && !branch_i;

  always_comb begin
    push_entry       = '0;
    push_entry.addr  = addr_q;
    push_entry.rdata = ram_rdata_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i)  state_d = RUN;
      RUN:     if (!req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pc_d = pc_q;
    if (branch_i)   pc_d = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
    else if (issue) pc_d = pc_q + ADDR_WIDTH'(WORD_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
      drop_q     <= branch_i && issue;
      if (issue) addr_q <= pc_q;
    end
  end

  fetch_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (branch_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign fetch_valid_o = (count != '0);
  assign fetch_rdata_o = head.rdata;
  assign fetch_addr_o  = head.addr;

  assign ram_en_o    = issue;
  assign ram_addr_o  = pc_q;
  assign ram_we_o    = 1'b0;
  assign ram_be_o    = '1;
  assign ram_wdata_o = '0;

endmodule
